// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared widths, register-zero constant and byte-lane offsets
package writeback_unit_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
endpackage

// File: rtl/writeback_unit_load_byte_extend.sv
// load_byte_extend: picks one little-endian byte lane and sign/zero extends it
module load_byte_extend
    import writeback_unit_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [31:0]  word_i,
    input  logic [1:0]   offset_i,
    input  logic         sext_i,
    output logic [W-1:0] data_o
);
    logic [7:0] byte_sel;
    // lane mux then extension
    always_comb begin
        byte_sel = (offset_i == LANE_B3) ? word_i[31:24] :
                   (offset_i == LANE_B2) ? word_i[23:16] :
                   (offset_i == LANE_B1) ? word_i[15:8]  : word_i[7:0];
        data_o   = {{(W-8){sext_i & byte_sel[7]}}, byte_sel};
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB consumer producing the register-file write, a one-cycle forward hold and debug counters
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int RETIRE_W   = 32,
    parameter int SUPP_W     = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  ValidIn,
    input  logic                  RegWriteIn,
    input  logic                  MoveNotZeroIn,
    input  logic                  DontMoveIn,
    input  logic                  HiOrLoIn,
    input  logic                  MemToRegIn,
    input  logic                  HiLoToRegIn,
    input  logic [DATA_WIDTH-1:0] RHiIn,
    input  logic [DATA_WIDTH-1:0] RLoIn,
    input  logic                  ZeroIn,
    input  logic [DATA_WIDTH-1:0] ALUResultIn,
    input  logic [ADDR_WIDTH-1:0] WriteAddressIn,
    input  logic [DATA_WIDTH-1:0] ReadDataIn,
    input  logic                  LbIn,
    input  logic                  LoadExtendedIn,
    input  logic [ADDR_WIDTH-1:0] ReadAddrA,
    input  logic [ADDR_WIDTH-1:0] ReadAddrB,
    output logic                  RegWriteEn,
    output logic [ADDR_WIDTH-1:0] RegWriteAddr,
    output logic [DATA_WIDTH-1:0] RegWriteData,
    output logic                  FwdA,
    output logic                  FwdB,
    output logic [DATA_WIDTH-1:0] FwdData,
    output logic [RETIRE_W-1:0]   RetireCount,
    output logic [SUPP_W-1:0]     SuppressCount
);
    logic                  move_ok;
    logic                  supp_hit;
    logic [DATA_WIDTH-1:0] byte_data;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  held_valid_q, held_valid_d;
    logic [ADDR_WIDTH-1:0] held_addr_q, held_addr_d;
    logic [DATA_WIDTH-1:0] held_data_q, held_data_d;
    logic [RETIRE_W-1:0]   retire_q, retire_d;
    logic [SUPP_W-1:0]     supp_q, supp_d;

    load_byte_extend #(.W(DATA_WIDTH)) u_lbe (
        .word_i   (ReadDataIn[31:0]),
        .offset_i (ALUResultIn[1:0]),
        .sext_i   (LoadExtendedIn),
        .data_o   (byte_data)
    );

    // write port selection and enable; a failed conditional move is counted but the $0 check is not
    always_comb begin
        move_ok      = !DontMoveIn | (MoveNotZeroIn ? !ZeroIn : ZeroIn);
        load_data    = LbIn ? byte_data : ReadDataIn;
        RegWriteData = HiLoToRegIn ? (HiOrLoIn ? RHiIn : RLoIn) :
                       MemToRegIn  ? load_data : ALUResultIn;
        RegWriteAddr = WriteAddressIn;
        RegWriteEn   = ValidIn & RegWriteIn & move_ok & (WriteAddressIn != REG_ZERO);
        supp_hit     = ValidIn & RegWriteIn & DontMoveIn & !move_ok;
        held_valid_d = RegWriteEn;
        held_addr_d  = RegWriteAddr;
        held_data_d  = RegWriteData;
        retire_d     = ValidIn ? retire_q + 1'b1 : retire_q;
        supp_d       = (supp_hit && supp_q != '1) ? supp_q + 1'b1 : supp_q;
    end

    // forward hold and counters, reset taking priority over the incoming slot
    always_ff @(posedge Clk) begin
        if (Rst) begin
            held_valid_q <= 1'b0;
            held_addr_q  <= '0;
            held_data_q  <= '0;
            retire_q     <= '0;
            supp_q       <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            held_addr_q  <= held_addr_d;
            held_data_q  <= held_data_d;
            retire_q     <= retire_d;
            supp_q       <= supp_d;
        end
    end

    assign FwdA          = held_valid_q & (held_addr_q == ReadAddrA);
    assign FwdB          = held_valid_q & (held_addr_q == ReadAddrB);
    assign FwdData       = held_data_q;
    assign RetireCount   = retire_q;
    assign SuppressCount = supp_q;
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed checks of write select, forwarding, counters and reset
module tb_writeback_unit;
    logic        Clk = 0, Rst = 1;
    logic        ValidIn, RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn;
    logic        MemToRegIn, HiLoToRegIn, ZeroIn, LbIn, LoadExtendedIn;
    logic [31:0] RHiIn, RLoIn, ALUResultIn, ReadDataIn;
    logic [4:0]  WriteAddressIn, ReadAddrA, ReadAddrB;
    logic        RegWriteEn, FwdA, FwdB;
    logic [4:0]  RegWriteAddr;
    logic [31:0] RegWriteData, FwdData, RetireCount;
    logic [15:0] SuppressCount;
    int tests = 0, fails = 0;

    writeback_unit dut (
        .Clk(Clk), .Rst(Rst), .ValidIn(ValidIn), .RegWriteIn(RegWriteIn),
        .MoveNotZeroIn(MoveNotZeroIn), .DontMoveIn(DontMoveIn), .HiOrLoIn(HiOrLoIn),
        .MemToRegIn(MemToRegIn), .HiLoToRegIn(HiLoToRegIn), .RHiIn(RHiIn), .RLoIn(RLoIn),
        .ZeroIn(ZeroIn), .ALUResultIn(ALUResultIn), .WriteAddressIn(WriteAddressIn),
        .ReadDataIn(ReadDataIn), .LbIn(LbIn), .LoadExtendedIn(LoadExtendedIn),
        .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB), .RegWriteEn(RegWriteEn),
        .RegWriteAddr(RegWriteAddr), .RegWriteData(RegWriteData), .FwdA(FwdA), .FwdB(FwdB),
        .FwdData(FwdData), .RetireCount(RetireCount), .SuppressCount(SuppressCount)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ValidIn = 0; RegWriteIn = 0; MoveNotZeroIn = 0; DontMoveIn = 0; HiOrLoIn = 0;
        MemToRegIn = 0; HiLoToRegIn = 0; ZeroIn = 0; LbIn = 0; LoadExtendedIn = 0;
        RHiIn = 0; RLoIn = 0; ALUResultIn = 0; ReadDataIn = 0;
        WriteAddressIn = 0; ReadAddrA = 0; ReadAddrB = 0;
    endtask

    task automatic do_reset();
        Rst = 1;
        step();
        Rst = 0;
    endtask

    task automatic test_reset();
        idle();
        ReadAddrA = 8;
        do_reset();
        tests++; if (RetireCount !== 32'd0) begin fails++; $display("FAIL reset_retire got %h want 0", RetireCount); end
        tests++; if (SuppressCount !== 16'd0) begin fails++; $display("FAIL reset_supp got %h want 0", SuppressCount); end
        tests++; if (FwdA !== 1'b0 || FwdData !== 32'd0) begin fails++; $display("FAIL reset_fwd got %b/%h want 0/0", FwdA, FwdData); end
    endtask

    task automatic test_alu_write();
        idle();
        ValidIn = 1; RegWriteIn = 1; WriteAddressIn = 8; ALUResultIn = 32'h1234;
        #1;
        tests++; if (RegWriteEn !== 1'b1) begin fails++; $display("FAIL alu_en got %b want 1", RegWriteEn); end
        tests++; if (RegWriteAddr !== 5'd8) begin fails++; $display("FAIL alu_addr got %0d want 8", RegWriteAddr); end
        tests++; if (RegWriteData !== 32'h1234) begin fails++; $display("FAIL alu_data got %h want 1234", RegWriteData); end
        step();
        idle();
        ReadAddrA = 8; ReadAddrB = 9;
        #1;
        tests++; if (FwdA !== 1'b1 || FwdB !== 1'b0) begin fails++; $display("FAIL alu_fwd got A=%b B=%b want A=1 B=0", FwdA, FwdB); end
        tests++; if (FwdData !== 32'h1234) begin fails++; $display("FAIL alu_fwddata got %h want 1234", FwdData); end
        tests++; if (RetireCount !== 32'd1) begin fails++; $display("FAIL alu_retire got %0d want 1", RetireCount); end
        step();
        tests++; if (FwdA !== 1'b0) begin fails++; $display("FAIL alu_fwd_expire got %b want 0", FwdA); end
    endtask

    task automatic test_byte_load();
        logic [1:0]  offs [6] = '{2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd2};
        logic        sext [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] want [6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
                                  32'h00000001, 32'hFFFFFFFF, 32'h000000FF};
        idle();
        MemToRegIn = 1; LbIn = 1; ReadDataIn = 32'h80FF7F01;
        for (int i = 0; i < 6; i++) begin
            ALUResultIn = {30'h100, offs[i]}; LoadExtendedIn = sext[i];
            #1;
            tests++; if (RegWriteData !== want[i]) begin fails++; $display("FAIL lb_%0d got %h want %h", i, RegWriteData, want[i]); end
        end
        LbIn = 0;
        #1;
        tests++; if (RegWriteData !== 32'h80FF7F01) begin fails++; $display("FAIL lw_word got %h want 80ff7f01", RegWriteData); end
    endtask

    task automatic test_cond_move();
        idle();
        do_reset();
        ValidIn = 1; RegWriteIn = 1; DontMoveIn = 1; MoveNotZeroIn = 0; ZeroIn = 0;
        WriteAddressIn = 9; ALUResultIn = 32'h99; ReadAddrB = 9;
        #1;
        tests++; if (RegWriteEn !== 1'b0) begin fails++; $display("FAIL movz_en got %b want 0", RegWriteEn); end
        step();
        ValidIn = 0;
        #1;
        tests++; if (SuppressCount !== 16'd1 || RetireCount !== 32'd1) begin fails++; $display("FAIL movz_counts got s=%0d r=%0d want s=1 r=1", SuppressCount, RetireCount); end
        tests++; if (FwdB !== 1'b0) begin fails++; $display("FAIL movz_fwd got %b want 0", FwdB); end
        ValidIn = 1; MoveNotZeroIn = 1; ZeroIn = 0;
        #1;
        tests++; if (RegWriteEn !== 1'b1) begin fails++; $display("FAIL movn_en got %b want 1", RegWriteEn); end
        MoveNotZeroIn = 0; ZeroIn = 1;
        #1;
        tests++; if (RegWriteEn !== 1'b1) begin fails++; $display("FAIL movz_taken_en got %b want 1", RegWriteEn); end
        step();
        ValidIn = 0;
        #1;
        tests++; if (SuppressCount !== 16'd1 || RetireCount !== 32'd2) begin fails++; $display("FAIL move_counts got s=%0d r=%0d want s=1 r=2", SuppressCount, RetireCount); end
        tests++; if (FwdB !== 1'b1 || FwdData !== 32'h99) begin fails++; $display("FAIL move_fwd got %b/%h want 1/99", FwdB, FwdData); end
    endtask

    task automatic test_hilo();
        idle();
        ValidIn = 1; RegWriteIn = 1; HiLoToRegIn = 1; HiOrLoIn = 1; MemToRegIn = 1;
        RHiIn = 32'hDEADBEEF; RLoIn = 32'hCAFEF00D; ALUResultIn = 32'h55; WriteAddressIn = 5;
        #1;
        tests++; if (RegWriteData !== 32'hDEADBEEF || RegWriteEn !== 1'b1) begin fails++; $display("FAIL hi_data got %h/%b want deadbeef/1", RegWriteData, RegWriteEn); end
        HiOrLoIn = 0;
        #1;
        tests++; if (RegWriteData !== 32'hCAFEF00D) begin fails++; $display("FAIL lo_data got %h want cafef00d", RegWriteData); end
        HiOrLoIn = 1; WriteAddressIn = 0;
        #1;
        tests++; if (RegWriteEn !== 1'b0 || RegWriteAddr !== 5'd0 || RegWriteData !== 32'hDEADBEEF) begin fails++; $display("FAIL zero_dest got en=%b a=%0d d=%h want 0/0/deadbeef", RegWriteEn, RegWriteAddr, RegWriteData); end
        step();
        ValidIn = 0; ReadAddrA = 0; ReadAddrB = 0;
        #1;
        tests++; if (FwdA !== 1'b0 || FwdB !== 1'b0) begin fails++; $display("FAIL zero_fwd got %b%b want 00", FwdA, FwdB); end
        tests++; if (SuppressCount !== 16'd1) begin fails++; $display("FAIL zero_not_supp got %0d want 1", SuppressCount); end
    endtask

    task automatic test_bubble();
        logic [31:0] r;
        idle();
        r = RetireCount;
        RegWriteIn = 1; WriteAddressIn = 7; ALUResultIn = 32'h77; ReadAddrA = 7;
        #1;
        tests++; if (RegWriteEn !== 1'b0) begin fails++; $display("FAIL bubble_en got %b want 0", RegWriteEn); end
        step();
        tests++; if (RetireCount !== r || FwdA !== 1'b0) begin fails++; $display("FAIL bubble_state got r=%0d fwd=%b want r=%0d fwd=0", RetireCount, FwdA, r); end
    endtask

    task automatic test_saturation();
        idle();
        do_reset();
        ValidIn = 1; RegWriteIn = 1; DontMoveIn = 1; MoveNotZeroIn = 1; ZeroIn = 1; WriteAddressIn = 3;
        for (int i = 0; i < 65535; i++) @(posedge Clk);
        #1;
        tests++; if (SuppressCount !== 16'hFFFF) begin fails++; $display("FAIL supp_reach got %h want ffff", SuppressCount); end
        step();
        tests++; if (SuppressCount !== 16'hFFFF) begin fails++; $display("FAIL supp_sat got %h want ffff", SuppressCount); end
        tests++; if (RetireCount !== 32'd65536) begin fails++; $display("FAIL supp_retire got %0d want 65536", RetireCount); end
    endtask

    task automatic test_reset_mid();
        idle();
        do_reset();
        ValidIn = 1; RegWriteIn = 1; WriteAddressIn = 3; ALUResultIn = 32'h33;
        for (int i = 0; i < 5; i++) step();
        tests++; if (RetireCount !== 32'd5) begin fails++; $display("FAIL mid_retire5 got %0d want 5", RetireCount); end
        WriteAddressIn = 4; ALUResultIn = 32'h44; Rst = 1;
        step();
        Rst = 0; ValidIn = 0; ReadAddrA = 4; ReadAddrB = 3;
        #1;
        tests++; if (RetireCount !== 32'd0) begin fails++; $display("FAIL mid_retire got %0d want 0", RetireCount); end
        tests++; if (FwdA !== 1'b0 || FwdB !== 1'b0 || FwdData !== 32'd0) begin fails++; $display("FAIL mid_fwd got %b%b/%h want 00/0", FwdA, FwdB, FwdData); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_byte_load();
        test_cond_move();
        test_hilo();
        test_bubble();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Consumer end of the MEM/WB pipeline register: takes the latched MEM/WB fields and produces the single register-file write (address, data, enable).
- Applies MEM/WB side effects: byte-load extraction/extension, HI/LO moves, conditional-move suppression, and $0 write blocking.
- Holds the last committed write for one cycle as a forwarding source for the decode stage.
- Keeps retire and suppressed-move counters for debug.

Parameters:
- DATA_WIDTH, 32, register/data width
- ADDR_WIDTH, 5, register address width
- RETIRE_W, 32, retire counter width (wraps)
- SUPP_W, 16, suppressed-move counter width (saturates)

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  synchronous active-high reset
- ValidIn  in  1  MEM/WB slot holds a real instruction (0 = bubble)
- RegWriteIn  in  1  instruction writes a register
- MoveNotZeroIn  in  1  conditional move is movn (1) or movz (0)
- DontMoveIn  in  1  instruction is a conditional move (write depends on ZeroIn)
- HiOrLoIn  in  1  select HI (1) or LO (0) when HiLoToRegIn
- MemToRegIn  in  1  write data comes from memory
- HiLoToRegIn  in  1  write data comes from HI/LO
- RHiIn, RLoIn  in  32  HI/LO values
- ZeroIn  in  1  rt==0 flag from EX
- ALUResultIn  in  32  ALU result, or memory address for loads
- WriteAddressIn  in  5  destination register
- ReadDataIn  in  32  memory read word
- LbIn  in  1  load byte
- LoadExtendedIn  in  1  sign-extend (1) / zero-extend (0) byte
- ReadAddrA, ReadAddrB  in  5  decode-stage source registers
- RegWriteEn  out  1  register-file write enable (combinational)
- RegWriteAddr  out  5  register-file write address (combinational)
- RegWriteData  out  32  register-file write data (combinational)
- FwdA, FwdB  out  1  decode source matches the held last write
- FwdData  out  32  held last-write data
- RetireCount  out  32  instructions retired
- SuppressCount  out  16  conditional moves suppressed

Behaviour:
- Data select, priority order: HiLoToRegIn → (HiOrLoIn ? RHiIn : RLoIn); else MemToRegIn → load data; else ALUResultIn.
- Load data: if LbIn, byte = ReadDataIn[8*k+7:8*k] with k = ALUResultIn[1:0] (k=0 → bits 7:0, little-endian). Extend to 32 bits: sign if LoadExtendedIn, zero otherwise. If LbIn is 0, load data = ReadDataIn.
- Move condition: moveOK = !DontMoveIn | (MoveNotZeroIn ? !ZeroIn : ZeroIn).
- RegWriteEn = ValidIn & RegWriteIn & moveOK & (WriteAddressIn != 0). Purely combinational, zero latency.
- RegWriteAddr = WriteAddressIn; RegWriteData = selected data. Both are driven even when RegWriteEn is 0.
- Forward hold registers (HeldValid, HeldAddr, HeldData), updated every posedge with the current RegWriteEn/Addr/Data. HeldValid=0 after a bubble or a suppressed write.
- FwdA = HeldValid & (HeldAddr == ReadAddrA); FwdB likewise with ReadAddrB; FwdData = HeldData. One-cycle latency.
- ReadAddr = 0 never forwards, because HeldValid can only be set by a nonzero address.
- RetireCount += 1 on each posedge with ValidIn=1, including suppressed moves and non-writing instructions. Wraps from 0xFFFFFFFF to 0.
- SuppressCount += 1 when ValidIn & RegWriteIn & DontMoveIn & !moveOK. Saturates at 0xFFFF.
- A $0 destination write is not counted as suppressed.
- Rst (synchronous, sampled at posedge) clears HeldValid, HeldAddr, HeldData, RetireCount, SuppressCount to 0. Reset wins over a simultaneous valid instruction, so that cycle is neither counted nor held.
- Combinational outputs are not gated by Rst.

Decomposition:
- Shared package constants: data/address widths, REG_ZERO=5'd0, byte-lane offset encodings.
- One sub-module, load_byte_extend: takes the word, offset, and sign-extend flag; returns the extended 32-bit value. Reusable for a future lh path.

Test Plan:
- ALU write: ValidIn=1, RegWriteIn=1, WriteAddressIn=8, ALUResultIn=0x1234 → RegWriteEn=1, data 0x1234. Next cycle with ReadAddrA=8 → FwdA=1, FwdData=0x1234.
- Byte load: ReadDataIn=0x80FF7F01, ALUResultIn[1:0]=3, LbIn=1. LoadExtendedIn=1 → 0xFFFFFF80; LoadExtendedIn=0 → 0x00000080; offset 1, signed → 0x0000007F.
- Conditional moves: movz (DontMove=1, MoveNotZero=0) with ZeroIn=0 → RegWriteEn=0, SuppressCount=1, RetireCount=1. movn with ZeroIn=0 → write occurs.
- HI/LO: HiLoToRegIn=1, HiOrLoIn=1, RHiIn=0xDEADBEEF → data 0xDEADBEEF. With WriteAddressIn=0 → RegWriteEn=0, FwdA stays 0 for ReadAddrA=0.
- Bubble and saturation: ValidIn=0 → no write, RetireCount unchanged. Preload SuppressCount=0xFFFF and apply a suppressed move → stays 0xFFFF.
- Reset mid-stream: after 5 retires, assert Rst in the same cycle as a valid write → next cycle RetireCount=0, FwdA=FwdB=0.
